// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo datapath: widths, instruction field
// positions, adder opcodes, FU state encoding and the adder result function.
package tomasulo_pkg;

  localparam int DATA_W  = 16;
  localparam int TAG_W   = 3;
  localparam int SEL_W   = 3;
  localparam int OPC_W   = 4;
  localparam int CNT_W   = 4;

  localparam int OPC_LSB = 0;
  localparam int RX_LSB  = 4;
  localparam int RY_LSB  = 7;
  localparam int RZ_LSB  = 10;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } fu_state_e;

  // Immediate ops reuse the Ry field as a 3-bit signed constant.
  function automatic logic [DATA_W-1:0] fu_compute(
    input logic [OPC_W-1:0]  opc,
    input logic [SEL_W-1:0]  imm,
    input logic [DATA_W-1:0] op1,
    input logic [DATA_W-1:0] op2
  );
    logic [DATA_W-1:0] imm_ext;
    imm_ext = {{(DATA_W-SEL_W){imm[SEL_W-1]}}, imm};
    case (opc)
      OP_ADD:  fu_compute = op1 + op2;
      OP_SUB:  fu_compute = op1 - op2;
      OP_ADDI: fu_compute = op1 + imm_ext;
      OP_SUBI: fu_compute = op1 - imm_ext;
      default: fu_compute = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/adder_functional_unit_if.sv
// Issue and result-broadcast bundle between the adder reservation station
// and the adder functional unit.
interface adder_functional_unit_if;
  import tomasulo_pkg::*;

  logic [DATA_W-1:0] instruction;
  logic              instEnable;
  logic [TAG_W-1:0]  instructionCodeIn;
  logic              disponivel;
  logic              done;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] doneInst;
  logic [TAG_W-1:0]  instructionCodeOut;

  modport master (
    output instruction, instEnable, instructionCodeIn,
    input  disponivel, done, dout, doneInst, instructionCodeOut
  );

  modport slave (
    input  instruction, instEnable, instructionCodeIn,
    output disponivel, done, dout, doneInst, instructionCodeOut
  );

endinterface

// File: rtl/adder_functional_unit_chk.sv
// Structural invariants of the adder FU state machine and its outputs.
module adder_functional_unit_chk
  import tomasulo_pkg::*;
(
  input logic      Clock,
  input logic      Resetn,
  input fu_state_e state,
  input logic      done,
  input logic      disponivel
);

  done_tracks_state: assert property (@(posedge Clock) disable iff (!Resetn)
    done == (state == DONE));

  busy_only_in_exec: assert property (@(posedge Clock) disable iff (!Resetn)
    disponivel == (state != EXEC));

  no_illegal_state: assert property (@(posedge Clock) disable iff (!Resetn)
    state != 2'b11);

endmodule

// File: rtl/operand_mux.sv
// 8:1 register-file operand selector; code 0 is the hardwired zero register.
module operand_mux
  import tomasulo_pkg::*;
(
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] r3,
  input  logic [DATA_W-1:0] r4,
  input  logic [DATA_W-1:0] r5,
  input  logic [DATA_W-1:0] r6,
  input  logic [DATA_W-1:0] r7,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] operand
);

  // select one architectural register value by code
  always_comb begin
    operand = 16'h0000;
    case (sel)
      3'd1:    operand = r1;
      3'd2:    operand = r2;
      3'd3:    operand = r3;
      3'd4:    operand = r4;
      3'd5:    operand = r5;
      3'd6:    operand = r6;
      3'd7:    operand = r7;
      default: operand = 16'h0000;
    endcase
  end

endmodule

// File: rtl/adder_functional_unit.sv
// Multi-cycle integer add/subtract functional unit: captures operands at issue,
// counts out a fixed latency, then broadcasts result, instruction and tag.
module adder_functional_unit
  import tomasulo_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [DATA_W-1:0]       R1,
  input  logic [DATA_W-1:0]       R2,
  input  logic [DATA_W-1:0]       R3,
  input  logic [DATA_W-1:0]       R4,
  input  logic [DATA_W-1:0]       R5,
  input  logic [DATA_W-1:0]       R6,
  input  logic [DATA_W-1:0]       R7,
  adder_functional_unit_if.slave  fu
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  fu_state_e         state_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] instr_r;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] op1_r;
  logic [DATA_W-1:0] op2_r;
  logic              done_r;
  logic [DATA_W-1:0] dout_r;
  logic [DATA_W-1:0] done_inst_r;
  logic [TAG_W-1:0]  tag_out_r;

  logic [DATA_W-1:0] op1_s;
  logic [DATA_W-1:0] op2_s;
  logic              disponivel_s;
  logic              accept_s;
  logic [DATA_W-1:0] live_result_s;
  logic [DATA_W-1:0] held_result_s;

  operand_mux u_mux_rx (
    .r1(R1), .r2(R2), .r3(R3), .r4(R4), .r5(R5), .r6(R6), .r7(R7),
    .sel(fu.instruction[RX_LSB +: SEL_W]),
    .operand(op1_s)
  );

  operand_mux u_mux_ry (
    .r1(R1), .r2(R2), .r3(R3), .r4(R4), .r5(R5), .r6(R6), .r7(R7),
    .sel(fu.instruction[RY_LSB +: SEL_W]),
    .operand(op2_s)
  );

  // availability is a pure decode of the state, independent of instEnable
  always_comb begin
    disponivel_s = 1'b0;
    case (state_r)
      IDLE:    disponivel_s = 1'b1;
      EXEC:    disponivel_s = 1'b0;
      DONE:    disponivel_s = 1'b1;
      default: disponivel_s = 1'b0;
    endcase
  end

  assign accept_s = fu.instEnable & disponivel_s;

  // single-cycle units need the result straight from the live operands
  assign live_result_s = fu_compute(fu.instruction[OPC_LSB +: OPC_W],
                                    fu.instruction[RY_LSB +: SEL_W], op1_s, op2_s);
  assign held_result_s = fu_compute(instr_r[OPC_LSB +: OPC_W],
                                    instr_r[RY_LSB +: SEL_W], op1_r, op2_r);

  // issue capture, latency countdown and registered result broadcast
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r     <= IDLE;
      count_r     <= 4'd0;
      instr_r     <= 16'h0000;
      tag_r       <= 3'd0;
      op1_r       <= 16'h0000;
      op2_r       <= 16'h0000;
      done_r      <= 1'b0;
      dout_r      <= 16'h0000;
      done_inst_r <= 16'h0000;
      tag_out_r   <= 3'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            instr_r <= fu.instruction;
            tag_r   <= fu.instructionCodeIn;
            op1_r   <= op1_s;
            op2_r   <= op2_s;
            if (LATENCY == 1) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              dout_r      <= live_result_s;
              done_inst_r <= fu.instruction;
              tag_out_r   <= fu.instructionCodeIn;
            end else begin
              state_r <= EXEC;
              count_r <= LAT_M1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (count_r == 4'd1) begin
            state_r     <= DONE;
            done_r      <= 1'b1;
            dout_r      <= held_result_s;
            done_inst_r <= instr_r;
            tag_out_r   <= tag_r;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign fu.disponivel         = disponivel_s;
  assign fu.done               = done_r;
  assign fu.dout               = dout_r;
  assign fu.doneInst           = done_inst_r;
  assign fu.instructionCodeOut = tag_out_r;

  adder_functional_unit_chk u_chk (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .state      (state_r),
    .done       (done_r),
    .disponivel (disponivel_s)
  );

endmodule

// File: tb/tb_adder_functional_unit.sv
// Directed, table-driven bench for the adder functional unit (LATENCY=2).
module tb_adder_functional_unit;
  import tomasulo_pkg::*;

  localparam int LAT = 2;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] r [1:7];
  int          checks = 0;
  int          errors = 0;

  adder_functional_unit_if fu ();

  adder_functional_unit #(.LATENCY(LAT)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .R1(r[1]), .R2(r[2]), .R3(r[3]), .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
    .fu(fu)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  opc;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] vx;
    logic [15:0] vy;
    logic [2:0]  tag;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] opc, input logic [2:0] rx, input logic [2:0] ry);
    return {3'b000, 3'b110, ry, rx, opc};
  endfunction

  task automatic issue(input logic [15:0] instr, input logic [2:0] tag);
    int n;
    n = 0;
    @(negedge Clock);
    while (fu.disponivel !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 20) check("issue_wait_timeout", 32'd1, 32'd0);
    fu.instruction       = instr;
    fu.instructionCodeIn = tag;
    fu.instEnable        = 1'b1;
    @(posedge Clock);
    #1;
    fu.instEnable = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (fu.done !== 1'b1 && n < 20) begin
      @(posedge Clock);
      #1;
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge Clock);
      #1;
      if (fu.done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int          n;
    int          pulses;
    logic [15:0] instr;

    vecs[0] = '{opc:4'b0000, rx:3'd2, ry:3'd3, vx:16'd5,     vy:16'd7,  tag:3'd4, exp:16'd12};
    vecs[1] = '{opc:4'b0001, rx:3'd1, ry:3'd5, vx:16'd3,     vy:16'd10, tag:3'd1, exp:16'hFFF9};
    vecs[2] = '{opc:4'b0001, rx:3'd0, ry:3'd5, vx:16'd0,     vy:16'd0,  tag:3'd0, exp:16'h0000};
    vecs[3] = '{opc:4'b0001, rx:3'd0, ry:3'd5, vx:16'd0,     vy:16'd10, tag:3'd7, exp:16'hFFF6};
    vecs[4] = '{opc:4'b0000, rx:3'd0, ry:3'd5, vx:16'd0,     vy:16'd10, tag:3'd3, exp:16'd10};
    vecs[5] = '{opc:4'b0100, rx:3'd4, ry:3'd7, vx:16'd10,    vy:16'd50, tag:3'd5, exp:16'd9};
    vecs[6] = '{opc:4'b0101, rx:3'd6, ry:3'd2, vx:16'd100,   vy:16'd50, tag:3'd6, exp:16'd98};
    vecs[7] = '{opc:4'b0101, rx:3'd6, ry:3'd4, vx:16'd5,     vy:16'd50, tag:3'd2, exp:16'd9};
    vecs[8] = '{opc:4'b0000, rx:3'd7, ry:3'd1, vx:16'hFFFF,  vy:16'd2,  tag:3'd1, exp:16'h0001};
    vecs[9] = '{opc:4'b1111, rx:3'd2, ry:3'd3, vx:16'd5,     vy:16'd7,  tag:3'd4, exp:16'h0000};

    for (int i = 1; i <= 7; i++) r[i] = 16'hA5A5;
    fu.instruction       = mk(4'b0000, 3'd2, 3'd3);
    fu.instructionCodeIn = 3'd4;
    fu.instEnable        = 1'b1;

    // reset held with a live strobe
    repeat (3) @(posedge Clock);
    #1;
    check("rst_done", fu.done, 1'b0);
    check("rst_dout", fu.dout, 16'h0000);
    check("rst_inst", fu.doneInst, 16'h0000);
    check("rst_tag", fu.instructionCodeOut, 3'd0);
    check("rst_disp", fu.disponivel, 1'b1);
    @(negedge Clock);
    fu.instEnable = 1'b0;
    Resetn = 1'b1;
    count_done(4, pulses);
    check("idle_after_rst", pulses, 0);
    check("idle_disp", fu.disponivel, 1'b1);

    for (int i = 0; i < 10; i++) begin
      for (int k = 1; k <= 7; k++) r[k] = 16'hA5A5;
      if (vecs[i].rx != 3'd0) r[vecs[i].rx] = vecs[i].vx;
      if (vecs[i].ry != 3'd0) r[vecs[i].ry] = vecs[i].vy;
      instr = mk(vecs[i].opc, vecs[i].rx, vecs[i].ry);
      issue(instr, vecs[i].tag);
      check($sformatf("v%0d_busy", i), fu.disponivel, 1'b0);
      wait_done(n);
      check($sformatf("v%0d_latency", i), n, LAT - 1);
      check($sformatf("v%0d_dout", i), fu.dout, vecs[i].exp);
      check($sformatf("v%0d_inst", i), fu.doneInst, instr);
      check($sformatf("v%0d_tag", i), fu.instructionCodeOut, vecs[i].tag);
      check($sformatf("v%0d_disp_done", i), fu.disponivel, 1'b1);
      @(posedge Clock);
      #1;
      check($sformatf("v%0d_done_fall", i), fu.done, 1'b0);
      check($sformatf("v%0d_dout_hold", i), fu.dout, vecs[i].exp);
    end

    // issue attempt while busy is dropped
    r[2] = 16'd20; r[3] = 16'd22;
    issue(mk(4'b0000, 3'd2, 3'd3), 3'd2);
    fu.instruction       = mk(4'b0001, 3'd2, 3'd3);
    fu.instructionCodeIn = 3'd3;
    fu.instEnable        = 1'b1;
    check("busy_disp", fu.disponivel, 1'b0);
    wait_done(n);
    fu.instEnable = 1'b0;
    check("busy_latency", n, LAT - 1);
    check("busy_tag", fu.instructionCodeOut, 3'd2);
    check("busy_dout", fu.dout, 16'd42);
    count_done(6, pulses);
    check("busy_no_extra", pulses, 0);

    // back-to-back issue in the DONE cycle, operands captured at acceptance
    r[2] = 16'd5; r[3] = 16'd7;
    issue(mk(4'b0000, 3'd2, 3'd3), 3'd5);
    r[2] = 16'd100;
    wait_done(n);
    check("b2b_first_dout", fu.dout, 16'd12);
    check("b2b_first_tag", fu.instructionCodeOut, 3'd5);
    fu.instruction       = mk(4'b0000, 3'd2, 3'd3);
    fu.instructionCodeIn = 3'd6;
    fu.instEnable        = 1'b1;
    @(posedge Clock);
    #1;
    fu.instEnable = 1'b0;
    r[2] = 16'd1000;
    check("b2b_done_fall", fu.done, 1'b0);
    wait_done(n);
    check("b2b_spacing", n + 1, LAT);
    check("b2b_second_dout", fu.dout, 16'd107);
    check("b2b_second_tag", fu.instructionCodeOut, 3'd6);
    count_done(4, pulses);
    check("b2b_no_extra", pulses, 0);

    // reset during EXEC aborts the instruction
    r[4] = 16'd10;
    issue(mk(4'b0100, 3'd4, 3'd7), 3'd1);
    check("abort_busy", fu.disponivel, 1'b0);
    #1;
    Resetn = 1'b0;
    #1;
    check("abort_disp", fu.disponivel, 1'b1);
    check("abort_done", fu.done, 1'b0);
    check("abort_dout", fu.dout, 16'h0000);
    @(negedge Clock);
    Resetn = 1'b1;
    count_done(5, pulses);
    check("abort_no_done", pulses, 0);
    check("abort_disp_idle", fu.disponivel, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
